// File: rtl/spi_out.sv
// spi_out: SPI mode-0 master that streams a burst of 16-bit words, MSB first,
// read from a synchronous frame memory starting at address 0. All words share
// one CS-low window with a continuous SCK.
// Optional build macro SPI_OUT_READBACK_EN adds MISO capture (rx_data/rx_valid).
module spi_out #(
  parameter int ADDRESS_BUS_WIDTH = 12,
  parameter int CLK_DIV           = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDRESS_BUS_WIDTH:0]   word_count,
  output logic                         busy,
  output logic                         done,
  output logic [ADDRESS_BUS_WIDTH:0]   read_address,
  output logic                         read_strobe,
  input  logic [15:0]                  read_data,
  output logic                         cs,
  output logic                         sck,
  output logic                         mosi,
  input  logic                         miso
`ifdef SPI_OUT_READBACK_EN
  ,
  output logic [15:0]                  rx_data,
  output logic                         rx_valid
`endif
);

  localparam int CNT_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [ADDRESS_BUS_WIDTH:0] WL_ONE = (ADDRESS_BUS_WIDTH + 1)'(1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, HOLD, GAP} state_t;

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic [3:0]                   bit_cnt;
  logic [ADDRESS_BUS_WIDTH:0]   words_left;
  logic                         rd_vld_p1;
  logic [14:0]                  shreg;
  logic [15:0]                  pf_word_p1;

  // SCK edge events inside a word; bit_cnt counts 15 (first bit) down to 0
  logic half_end, rise_evt, fall_evt, word_end;
  assign half_end = (state == SHIFT) && (cnt == HALF_LAST);
  assign rise_evt = half_end && !sck;
  assign fall_evt = half_end && sck;
  assign word_end = fall_evt && (bit_cnt == 4'd0);

  // Control FSM: burst sequencing, SPI pins and memory read requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      words_left   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      read_strobe  <= 1'b0;
      read_address <= '0;
      rd_vld_p1    <= 1'b0;
      cs           <= 1'b1;
      sck          <= 1'b0;
      mosi         <= 1'b0;
    end else begin
      done        <= 1'b0;
      read_strobe <= 1'b0;
      rd_vld_p1   <= read_strobe;
      case (state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            read_address <= '0;
            words_left   <= word_count;
            if (word_count != '0) begin
              read_strobe <= 1'b1;
              cnt         <= '0;
              state       <= FETCH;
            end else begin
              // Empty burst: one GAP cycle, CS never asserted
              cnt   <= GAP_LAST;
              state <= GAP;
            end
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          cs      <= 1'b0;
          mosi    <= read_data[15];
          bit_cnt <= 4'd15;
          cnt     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (half_end) begin
            cnt <= '0;
            sck <= ~sck;
            if (!sck) begin
              // Prefetch the next word while the first bit of this one is out
              if (bit_cnt == 4'd15 && words_left != WL_ONE) begin
                read_strobe  <= 1'b1;
                read_address <= read_address + 1'b1;
              end
            end else if (bit_cnt == 4'd0) begin
              if (words_left == WL_ONE) begin
                state <= HOLD;
              end else begin
                mosi       <= pf_word_p1[15];
                bit_cnt    <= 4'd15;
                words_left <= words_left - 1'b1;
              end
            end else begin
              mosi    <= shreg[14];
              bit_cnt <= bit_cnt - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cnt == HALF_LAST) begin
            cs    <= 1'b1;
            mosi  <= 1'b0;
            cnt   <= '0;
            state <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path: TX shift register (bit 15 already on mosi) and prefetch word
  always_ff @(posedge clk) begin
    if (state == LOAD)
      shreg <= read_data[14:0];
    else if (word_end)
      shreg <= pf_word_p1[14:0];
    else if (fall_evt)
      shreg <= {shreg[13:0], 1'b0};
    if (rd_vld_p1)
      pf_word_p1 <= read_data;
  end

`ifdef SPI_OUT_READBACK_EN
  logic [14:0] rx_shreg;

  // MISO capture on every SCK rise
  always_ff @(posedge clk) begin
    if (rise_evt)
      rx_shreg <= {rx_shreg[13:0], miso};
  end

  // Publish the captured word after the 16th rise of each word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rise_evt && bit_cnt == 4'd0) begin
        rx_data  <= {rx_shreg, miso};
        rx_valid <= 1'b1;
      end
    end
  end
`else
  logic unused_miso;
  assign unused_miso = miso;
`endif

endmodule

// File: tb/tb_spi_out.sv
// tb_spi_out: directed bench for spi_out with a frame-memory model and an
// SPI-in receiver model (samples mosi on sck rises while cs is low).
module tb_spi_out;
  localparam int AW = 12;
  localparam int CD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic          busy, done, read_strobe, cs, sck, mosi, miso;
  logic [AW:0]   read_address;
  logic [15:0]   read_data = '0;
  logic [15:0]   miso_pat = 16'h0000;
`ifdef SPI_OUT_READBACK_EN
  logic [15:0]   rx_data;
  logic          rx_valid;
`endif

  int total = 0;
  int bad = 0;

  spi_out #(.ADDRESS_BUS_WIDTH(AW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .busy(busy), .done(done), .read_address(read_address),
    .read_strobe(read_strobe), .read_data(read_data),
    .cs(cs), .sck(sck), .mosi(mosi), .miso(miso)
`ifdef SPI_OUT_READBACK_EN
    , .rx_data(rx_data), .rx_valid(rx_valid)
`endif
  );

  always #5 clk = ~clk;

  // Frame memory model
  logic [15:0] mem [0:7];
  always @(posedge clk) if (read_strobe) read_data <= mem[read_address[2:0]];

  // Monitor and receiver model
  int cyc = 0, rises = 0, strobes = 0, cs_low = 0, dones = 0, busy_cyc = 0;
  int glitches = 0, gap_err = 0, last_rise = 0, win_rises = 0, n_words = 0;
  int cs_rise_cyc = 0, done_cyc = 0, rxv = 0;
  logic       sck_q = 1'b0, cs_q = 1'b1, mosi_q = 1'b0;
  logic [3:0] rx_bits = 4'd0;
  logic [15:0] rx_sh = '0;
  logic [15:0] words [0:63];
  logic [AW:0] saddr [0:63];

  assign miso = miso_pat[4'd15 - rx_bits];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (read_strobe) begin saddr[strobes % 64] <= read_address; strobes <= strobes + 1; end
    if (!cs) cs_low <= cs_low + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (done) begin dones <= dones + 1; done_cyc <= cyc; end
    if (cs && !cs_q) cs_rise_cyc <= cyc;
    if (!cs && !cs_q && mosi !== mosi_q && !(sck_q && !sck)) glitches <= glitches + 1;
`ifdef SPI_OUT_READBACK_EN
    if (rx_valid) rxv <= rxv + 1;
`endif
    if (cs) begin
      rx_bits <= 4'd0;
      win_rises <= 0;
    end else if (sck && !sck_q) begin
      rises <= rises + 1;
      win_rises <= win_rises + 1;
      last_rise <= cyc;
      if (win_rises > 0 && cyc - last_rise != 2 * CD) gap_err <= gap_err + 1;
      rx_sh <= {rx_sh[14:0], mosi};
      if (rx_bits == 4'd15) begin
        words[n_words % 64] <= {rx_sh[14:0], mosi};
        n_words <= n_words + 1;
        rx_bits <= 4'd0;
      end else begin
        rx_bits <= rx_bits + 4'd1;
      end
    end
    sck_q <= sck; cs_q <= cs; mosi_q <= mosi;
  end

  task automatic pulse_start(input int n);
    @(negedge clk); start = 1'b1; word_count = (AW+1)'(n);
    @(negedge clk); start = 1'b0; word_count = (AW+1)'(5);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL rst_cs got=%b want=1", cs); end
    total++; if (sck !== 1'b0) begin bad++; $display("FAIL rst_sck got=%b want=0", sck); end
    total++; if (mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi got=%b want=0", mosi); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (read_strobe !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b want=0", read_strobe); end
    total++; if (read_address !== '0) begin bad++; $display("FAIL rst_addr got=%0d want=0", read_address); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word;
    bit ok;
    int s_cs, s_r, s_st, s_d, s_w, s_g, s_ge;
    mem[0] = 16'hA55A;
    s_cs = cs_low; s_r = rises; s_st = strobes; s_d = dones; s_w = n_words; s_g = glitches; s_ge = gap_err;
    pulse_start(1);
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_done_timeout got=0 want=1"); end
    @(negedge clk);
    total++; if (cs_low - s_cs != 66) begin bad++; $display("FAIL single_cs_low got=%0d want=66", cs_low - s_cs); end
    total++; if (rises - s_r != 16) begin bad++; $display("FAIL single_sck_pulses got=%0d want=16", rises - s_r); end
    total++; if (strobes - s_st != 1) begin bad++; $display("FAIL single_strobes got=%0d want=1", strobes - s_st); end
    total++; if (saddr[s_st % 64] !== '0) begin bad++; $display("FAIL single_addr got=%0d want=0", saddr[s_st % 64]); end
    total++; if (dones - s_d != 1) begin bad++; $display("FAIL single_done_pulses got=%0d want=1", dones - s_d); end
    total++; if (n_words - s_w != 1 || words[s_w % 64] !== 16'hA55A) begin
      bad++; $display("FAIL single_word got=%h (n=%0d) want=a55a", words[s_w % 64], n_words - s_w); end
    total++; if (done_cyc - cs_rise_cyc != 2 * CD) begin bad++; $display("FAIL single_gap got=%0d want=%0d", done_cyc - cs_rise_cyc, 2 * CD); end
    total++; if (glitches != s_g) begin bad++; $display("FAIL single_mosi_stable got=%0d want=0", glitches - s_g); end
    total++; if (gap_err != s_ge) begin bad++; $display("FAIL single_sck_period got=%0d want=0", gap_err - s_ge); end
  endtask

  task automatic test_multi_word;
    bit ok;
    int s_cs, s_r, s_st, s_w, s_ge, s_g;
    logic [15:0] exp_w [0:2];
    exp_w[0] = 16'h0001; exp_w[1] = 16'h8000; exp_w[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) mem[i] = exp_w[i];
    s_cs = cs_low; s_r = rises; s_st = strobes; s_w = n_words; s_ge = gap_err; s_g = glitches;
    pulse_start(3);
    wait_done(600, ok);
    total++; if (!ok) begin bad++; $display("FAIL multi_done_timeout got=0 want=1"); end
    @(negedge clk);
    total++; if (rises - s_r != 48) begin bad++; $display("FAIL multi_sck_pulses got=%0d want=48", rises - s_r); end
    total++; if (gap_err != s_ge) begin bad++; $display("FAIL multi_continuous got=%0d want=0", gap_err - s_ge); end
    total++; if (cs_low - s_cs != 194) begin bad++; $display("FAIL multi_cs_low got=%0d want=194", cs_low - s_cs); end
    total++; if (strobes - s_st != 3) begin bad++; $display("FAIL multi_strobes got=%0d want=3", strobes - s_st); end
    total++; if (glitches != s_g) begin bad++; $display("FAIL multi_mosi_stable got=%0d want=0", glitches - s_g); end
    for (int i = 0; i < 3; i++) begin
      total++; if (saddr[(s_st + i) % 64] !== (AW+1)'(i)) begin
        bad++; $display("FAIL multi_addr%0d got=%0d want=%0d", i, saddr[(s_st + i) % 64], i); end
      total++; if (words[(s_w + i) % 64] !== exp_w[i]) begin
        bad++; $display("FAIL multi_word%0d got=%h want=%h", i, words[(s_w + i) % 64], exp_w[i]); end
    end
  endtask

  task automatic test_zero_count;
    bit ok;
    int s_cs, s_st, s_d, s_b;
    s_cs = cs_low; s_st = strobes; s_d = dones; s_b = busy_cyc;
    pulse_start(0);
    wait_done(20, ok);
    total++; if (!ok) begin bad++; $display("FAIL zero_done_timeout got=0 want=1"); end
    repeat (3) @(negedge clk);
    total++; if (busy_cyc - s_b != 1) begin bad++; $display("FAIL zero_busy_cycles got=%0d want=1", busy_cyc - s_b); end
    total++; if (dones - s_d != 1) begin bad++; $display("FAIL zero_done_pulses got=%0d want=1", dones - s_d); end
    total++; if (strobes != s_st) begin bad++; $display("FAIL zero_strobes got=%0d want=0", strobes - s_st); end
    total++; if (cs_low != s_cs) begin bad++; $display("FAIL zero_cs_low got=%0d want=0", cs_low - s_cs); end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int s_st, s_d, s_w;
    mem[0] = 16'h1234;
    s_st = strobes; s_d = dones; s_w = n_words;
    @(negedge clk); start = 1'b1; word_count = (AW+1)'(1);
    repeat (50) @(negedge clk);
    start = 1'b0;
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_done1_timeout got=0 want=1"); end
    // start asserted during the done cycle must be accepted
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", busy); end
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL b2b_cs_early1 got=%b want=1", cs); end
    @(negedge clk);
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL b2b_cs_early2 got=%b want=1", cs); end
    @(negedge clk);
    total++; if (cs !== 1'b0) begin bad++; $display("FAIL b2b_cs_fall got=%b want=0", cs); end
    wait_done(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL b2b_done2_timeout got=0 want=1"); end
    @(negedge clk);
    total++; if (dones - s_d != 2) begin bad++; $display("FAIL b2b_done_pulses got=%0d want=2", dones - s_d); end
    total++; if (strobes - s_st != 2) begin bad++; $display("FAIL b2b_strobes got=%0d want=2", strobes - s_st); end
    total++; if (n_words - s_w != 2 || words[s_w % 64] !== 16'h1234 || words[(s_w + 1) % 64] !== 16'h1234) begin
      bad++; $display("FAIL b2b_words got=%0d/%h/%h want=2/1234/1234", n_words - s_w, words[s_w % 64], words[(s_w + 1) % 64]); end
  endtask

  task automatic test_reset_mid_burst;
    bit ok;
    int s_r, s_w;
    mem[0] = 16'hFFFF;
    s_r = rises;
    pulse_start(1);
    for (int i = 0; i < 300; i++) begin
      if (rises - s_r >= 9) break;
      @(negedge clk);
    end
    total++; if (sck !== 1'b1 || cs !== 1'b0) begin bad++; $display("FAIL midrst_pre got=sck%b/cs%b want=sck1/cs0", sck, cs); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (cs !== 1'b1) begin bad++; $display("FAIL midrst_cs got=%b want=1", cs); end
    total++; if (sck !== 1'b0) begin bad++; $display("FAIL midrst_sck got=%b want=0", sck); end
    total++; if (mosi !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL midrst_mosi_busy got=%b/%b want=0/0", mosi, busy); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem[0] = 16'h3C96;
    s_r = rises; s_w = n_words;
    pulse_start(1);
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL midrst_done_timeout got=0 want=1"); end
    @(negedge clk);
    total++; if (rises - s_r != 16) begin bad++; $display("FAIL midrst_sck_pulses got=%0d want=16", rises - s_r); end
    total++; if (n_words - s_w != 1 || words[s_w % 64] !== 16'h3C96) begin
      bad++; $display("FAIL midrst_word got=%h (n=%0d) want=3c96", words[s_w % 64], n_words - s_w); end
  endtask

`ifdef SPI_OUT_READBACK_EN
  task automatic test_readback;
    bit ok;
    int s_v;
    mem[0] = 16'h5A5A;
    miso_pat = 16'hC3C3;
    s_v = rxv;
    pulse_start(1);
    wait_done(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL rb_done_timeout got=0 want=1"); end
    @(negedge clk);
    total++; if (rx_data !== 16'hC3C3) begin bad++; $display("FAIL rb_data got=%h want=c3c3", rx_data); end
    total++; if (rxv - s_v != 1) begin bad++; $display("FAIL rb_valid_pulses got=%0d want=1", rxv - s_v); end
    miso_pat = 16'h0000;
  endtask
`endif

  initial begin
    test_reset;
    test_single_word;
    test_multi_word;
    test_zero_count;
    test_back_to_back;
    test_reset_mid_burst;
`ifdef SPI_OUT_READBACK_EN
    test_readback;
`endif
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
